// File: rtl/seg7_frame_receiver.sv
// Serial seven-segment frame receiver: shifts in 7 segment bits (g first),
// decodes the pattern to a hex nibble and keeps a sticky error flag.
module seg7_frame_receiver (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    logic clk, rst_n, seg_bit, frame, pol, err_clr;
    logic unused_io;

    assign clk     = io_in[0];
    assign rst_n   = io_in[1];
    assign seg_bit = io_in[2];
    assign frame   = io_in[3];
    assign pol     = io_in[4];
    assign err_clr = io_in[5];
    assign unused_io = ^io_in[7:6];

    state_t      state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [6:0]  pattern_q, pattern_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  dcnt_q, dcnt_d;

    logic        decode, err_set;
    logic [6:0]  lookup_pat;
    logic        lut_hit;
    logic [3:0]  lut_nib;

    assign lookup_pat = pol ? ~pattern_q : pattern_q;

    always_comb begin
        lut_hit = 1'b1;
        lut_nib = 4'h0;
        case (lookup_pat)
            7'h3F: lut_nib = 4'h0;
            7'h06: lut_nib = 4'h1;
            7'h5B: lut_nib = 4'h2;
            7'h4F: lut_nib = 4'h3;
            7'h66: lut_nib = 4'h4;
            7'h6D: lut_nib = 4'h5;
            7'h7D: lut_nib = 4'h6;
            7'h07: lut_nib = 4'h7;
            7'h7F: lut_nib = 4'h8;
            7'h6F: lut_nib = 4'h9;
            7'h77: lut_nib = 4'hA;
            7'h7C: lut_nib = 4'hB;
            7'h39: lut_nib = 4'hC;
            7'h5E: lut_nib = 4'hD;
            7'h79: lut_nib = 4'hE;
            7'h71: lut_nib = 4'hF;
            default: lut_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        pattern_d = pattern_q;
        nibble_d  = nibble_q;
        valid_d   = 1'b0;
        dcnt_d    = dcnt_q;
        decode    = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame) begin
                    pattern_d = {6'b0, seg_bit};
                    bcnt_d    = 3'd1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (frame) begin
                    if (bcnt_q == 3'd7) begin
                        state_d = OVERRUN;
                        err_set = 1'b1;
                    end else begin
                        pattern_d = {pattern_q[5:0], seg_bit};
                        bcnt_d    = bcnt_q + 3'd1;
                    end
                end else begin
                    state_d = IDLE;
                    if (bcnt_q == 3'd7) decode = 1'b1;
                    else                err_set = 1'b1;
                end
            end
            OVERRUN: begin
                if (!frame) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (decode) begin
            if (lut_hit) begin
                nibble_d = lut_nib;
                valid_d  = 1'b1;
                dcnt_d   = dcnt_q + 2'd1;
            end else begin
                err_set = 1'b1;
            end
        end

        // A new error beats a simultaneous clear.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcnt_q    <= 3'd0;
            pattern_q <= 7'd0;
            nibble_q  <= 4'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            dcnt_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            pattern_q <= pattern_d;
            nibble_q  <= nibble_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign io_out = {dcnt_q, err_q, valid_q, nibble_q};
endmodule

// File: tb/tb_seg7_frame_receiver.sv
// Bench for seg7_frame_receiver: vector table of frames, a valid/nibble
// scoreboard queue, and hand-written short-frame, overrun and reset sequences.
module tb_seg7_frame_receiver;
    logic       clk, rst_n, seg_bit, frame, pol, err_clr;
    logic [1:0] ign;
    logic [7:0] io_in, io_out;

    assign io_in = {ign, err_clr, pol, frame, seg_bit, rst_n, clk};

    seg7_frame_receiver dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [6:0] pat;
        logic       pol;
        logic       hit;
        logic [3:0] nib;
    } vec_t;

    vec_t       vecs[17];
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_nib;
    logic [1:0] exp_dcnt;
    logic       exp_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Every valid pulse must match the oldest expected nibble.
    always @(negedge clk) begin
        if (io_out[4]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("valid_nibble", int'(io_out[3:0]), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic f, input logic s, input logic p, input logic c);
        frame   = f;
        seg_bit = s;
        pol     = p;
        err_clr = c;
        ign     = 2'($urandom_range(0, 3));
        @(negedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_nibble"}, int'(io_out[3:0]), int'(exp_nib));
        check({tag, "_dcnt"},   int'(io_out[7:6]), int'(exp_dcnt));
        check({tag, "_err"},    int'(io_out[5]),   int'(exp_err));
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Sends nbits bits (g first) with pol randomised except at the decode edge.
    task automatic send_frame(input logic [6:0] pat, input logic pol_v, input int nbits,
                              input logic hit, input logic [3:0] nib);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b1, (i < 7) ? pat[6 - i] : 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        if (nbits == 7 && hit) begin
            exp_q.push_back(nib);
            exp_nib  = nib;
            exp_dcnt = exp_dcnt + 2'd1;
        end else begin
            exp_err = 1'b1;
        end
        drive(1'b0, 1'b0, pol_v, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{pat: ~7'h77, pol: 1'b1, hit: 1'b1, nib: 4'hA};
        vecs[1]  = '{pat: ~7'h7C, pol: 1'b1, hit: 1'b1, nib: 4'hB};
        vecs[2]  = '{pat: ~7'h39, pol: 1'b1, hit: 1'b1, nib: 4'hC};
        vecs[3]  = '{pat: ~7'h5E, pol: 1'b1, hit: 1'b1, nib: 4'hD};
        vecs[4]  = '{pat: 7'h6D,  pol: 1'b0, hit: 1'b1, nib: 4'h5};
        vecs[5]  = '{pat: 7'h3F,  pol: 1'b0, hit: 1'b1, nib: 4'h0};
        vecs[6]  = '{pat: ~7'h7F, pol: 1'b1, hit: 1'b1, nib: 4'h8};
        vecs[7]  = '{pat: 7'h4F,  pol: 1'b0, hit: 1'b1, nib: 4'h3};
        vecs[8]  = '{pat: 7'h00,  pol: 1'b0, hit: 1'b0, nib: 4'h0};
        vecs[9]  = '{pat: 7'h71,  pol: 1'b0, hit: 1'b1, nib: 4'hF};
        vecs[10] = '{pat: 7'h7D,  pol: 1'b0, hit: 1'b1, nib: 4'h6};
        vecs[11] = '{pat: ~7'h6F, pol: 1'b1, hit: 1'b1, nib: 4'h9};
        vecs[12] = '{pat: 7'h79,  pol: 1'b0, hit: 1'b1, nib: 4'hE};
        vecs[13] = '{pat: 7'h66,  pol: 1'b0, hit: 1'b1, nib: 4'h4};
        vecs[14] = '{pat: 7'h5B,  pol: 1'b0, hit: 1'b1, nib: 4'h2};
        vecs[15] = '{pat: 7'h07,  pol: 1'b0, hit: 1'b1, nib: 4'h7};
        vecs[16] = '{pat: 7'h7E,  pol: 1'b0, hit: 1'b0, nib: 4'h0};

        rst_n = 1'b0; frame = 1'b0; seg_bit = 1'b0; pol = 1'b0; err_clr = 1'b0; ign = 2'b00;
        exp_nib = 4'h0; exp_dcnt = 2'd0; exp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_io_out", int'(io_out), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_state("after_reset");

        // Table frames, mostly back-to-back with occasional idle gaps.
        for (int v = 0; v < 17; v++) begin
            send_frame(vecs[v].pat, vecs[v].pol, 7, vecs[v].hit, vecs[v].nib);
            check_state($sformatf("vec%0d", v));
            if (v >= 5) begin
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Clear, short frame, clear again, then recover with "1".
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_err = 1'b0;
        check("clr1_err", int'(io_out[5]), 0);
        send_frame(7'h00, 1'b0, 5, 1'b0, 4'h0);
        check_state("short");
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        exp_err = 1'b0;
        check("clr2_err", int'(io_out[5]), 0);
        send_frame(7'h06, 1'b0, 7, 1'b1, 4'h1);
        check_state("recover");

        // Overrun with err_clr colliding on the overrun edge.
        for (int c = 1; c <= 10; c++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c == 8);
            if (c == 7) check("ovr_pre_err", int'(io_out[5]), 0);
            if (c == 8) check("ovr_collide_err", int'(io_out[5]), 1);
        end
        exp_err = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_state("overrun");
        send_frame(7'h3F, 1'b0, 7, 1'b1, 4'h0);
        check_state("after_overrun");

        // Asynchronous reset between clock edges, mid-frame.
        send_frame(7'h4F, 1'b0, 7, 1'b1, 4'h3);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_io_out", int'(io_out), 0);
        exp_nib = 4'h0; exp_dcnt = 2'd0; exp_err = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("held_reset_io_out", int'(io_out), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_state("post_release");
        send_frame(7'h07, 1'b0, 7, 1'b1, 4'h7);
        check_state("after_reset_frame");

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
